// File: rtl/dht11_read_ctrl.sv
// dht11_read_ctrl: sequences DHT11 decoder reads with inter-read gap, timeout, checksum retry and a valid/ready result.
// Optional macro DHT11_LAST_GOOD_EN: failed results carry the last good reading on out_data.
module dht11_read_ctrl #(
    parameter int MIN_GAP_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    output logic        busy,
    output logic        sensor_enable,
    output logic        sensor_reset,
    input  logic        sensor_hold,
    input  logic        sensor_error,
    input  logic [7:0]  hum_int,
    input  logic [7:0]  hum_float,
    input  logic [7:0]  temp_int,
    input  logic [7:0]  temp_float,
    input  logic [7:0]  checksum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_status,
    output logic [1:0]  out_attempts
);
    typedef enum logic [2:0] {IDLE, GAP, PULSE, WAIT_START, WAIT_DONE, CHECK, OUTPUT} state_t;

    localparam logic [25:0] GAP_MAX   = 26'(MIN_GAP_CYCLES);
    localparam logic [25:0] TMO_LAST  = 26'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);

    state_t      state;
    logic [25:0] gap_cnt, tmo_cnt;
    logic [1:0]  retry, status;
    logic        pulse_2nd, err_seen, tmo_seen, tmo_hit;
    logic [7:0]  sum;
    logic [31:0] data, fail_data;

    assign sum     = hum_int + hum_float + temp_int + temp_float;
    assign data    = {hum_int, hum_float, temp_int, temp_float};
    assign tmo_hit = tmo_cnt >= TMO_LAST;
    // a timeout outranks a decoder error, which outranks a checksum mismatch
    assign status  = tmo_seen ? 2'b11 : err_seen ? 2'b10 : (sum != checksum) ? 2'b01 : 2'b00;

`ifdef DHT11_LAST_GOOD_EN
    logic [31:0] last_good;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_good <= '0;
        else if (state == CHECK && status == 2'b00)
            last_good <= data;
    end
    assign fail_data = last_good;
`else
    assign fail_data = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            sensor_enable <= 1'b1;
            sensor_reset  <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_status    <= 2'b00;
            out_attempts  <= 2'b00;
            gap_cnt       <= '0;
            tmo_cnt       <= '0;
            retry         <= 2'b00;
            pulse_2nd     <= 1'b0;
            err_seen      <= 1'b0;
            tmo_seen      <= 1'b0;
        end else begin
            sensor_enable <= 1'b1;
            if (gap_cnt != GAP_MAX)
                gap_cnt <= gap_cnt + 1'b1;
            if (!tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
                IDLE: if (request) begin
                    busy     <= 1'b1;
                    retry    <= 2'b00;
                    err_seen <= 1'b0;
                    tmo_seen <= 1'b0;
                    state    <= GAP;
                end
                GAP: if (gap_cnt == GAP_MAX) begin
                    sensor_reset <= 1'b1;
                    pulse_2nd    <= 1'b0;
                    gap_cnt      <= '0;
                    tmo_cnt      <= '0;
                    state        <= PULSE;
                end
                PULSE: begin
                    pulse_2nd <= 1'b1;
                    if (pulse_2nd) begin
                        sensor_reset <= 1'b0;
                        state        <= WAIT_START;
                    end
                end
                WAIT_START: if (tmo_hit) begin
                    tmo_seen <= 1'b1;
                    state    <= CHECK;
                end else if (sensor_hold)
                    state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (sensor_error)
                        err_seen <= 1'b1;
                    if (tmo_hit) begin
                        tmo_seen <= 1'b1;
                        state    <= CHECK;
                    end else if (!sensor_hold)
                        state <= CHECK;
                end
                CHECK: if (status != 2'b00 && retry < RETRY_MAX) begin
                    retry    <= retry + 1'b1;
                    err_seen <= 1'b0;
                    tmo_seen <= 1'b0;
                    state    <= GAP;
                end else begin
                    out_valid    <= 1'b1;
                    out_data     <= (status == 2'b00) ? data : fail_data;
                    out_status   <= status;
                    out_attempts <= retry;
                    state        <= OUTPUT;
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_read_ctrl.sv
// tb_dht11_read_ctrl: table vectors, randomized reads against a result model, backpressure and async reset sequences.
module tb_dht11_read_ctrl;
    localparam int GAP = 100, TMO = 500, RET = 2;
`ifdef DHT11_LAST_GOOD_EN
    localparam bit LG_EN = 1'b1;
`else
    localparam bit LG_EN = 1'b0;
`endif
    localparam logic [31:0] BASIC = 32'h28001900;
    localparam logic [31:0] LG_EXP = LG_EN ? BASIC : 32'h0;

    logic clock = 1'b0, reset = 1'b0, request = 1'b0, sensor_hold = 1'b0, sensor_error = 1'b0, out_ready = 1'b0;
    logic [7:0] hum_int = '0, hum_float = '0, temp_int = '0, temp_float = '0, checksum = '0;
    logic busy, sensor_enable, sensor_reset, out_valid;
    logic [31:0] out_data;
    logic [1:0] out_status, out_attempts;

    int checks = 0, failures = 0, cyc = 0, last_pulse = 0;
    int kind[3];
    logic [31:0] dat[3];
    logic [31:0] lg_model = '0;

    typedef struct {
        int k0, k1, k2;
        logic [31:0] d;
        logic [1:0] st, att;
        logic [31:0] od;
        int bp;
    } vec_t;
    vec_t vt[4];

    dht11_read_ctrl #(.MIN_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RET)) dut (
        .clock(clock), .reset(reset), .request(request), .busy(busy),
        .sensor_enable(sensor_enable), .sensor_reset(sensor_reset),
        .sensor_hold(sensor_hold), .sensor_error(sensor_error),
        .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int), .temp_float(temp_float),
        .checksum(checksum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status), .out_attempts(out_attempts)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            failures++;
            $display("FAIL %s actual=%0d required>=%0d", name, act, lim);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_enable"}, sensor_enable, 1'b1);
        check({tag, "_sreset"}, sensor_reset, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, 32'h0);
        check({tag, "_status"}, out_status, 2'b00);
        check({tag, "_attempts"}, out_attempts, 2'b00);
    endtask

    // Expected result from the attempt scripts: first clean attempt wins, else the last failure is reported.
    function automatic void model(output logic [1:0] st, output logic [1:0] att, output logic [31:0] od);
        st = 2'b11;
        att = 2'd2;
        od = LG_EN ? lg_model : 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (kind[i] == 0) begin
                st = 2'b00;
                att = 2'(i);
                od = dat[i];
                lg_model = dat[i];
                return;
            end
            st = 2'(kind[i]);
        end
    endfunction

    // Decoder behaviour for one attempt: 0 clean, 1 bad checksum, 2 error during hold, 3 silent.
    task automatic attempt(input int idx);
        int k;
        logic [31:0] d;
        k = (idx < 3) ? kind[idx] : 3;
        d = (idx < 3) ? dat[idx] : 32'h0;
        check_ge("pulse_gap", cyc - last_pulse, GAP);
        last_pulse = cyc;
        step();
        check("pulse_2nd_cycle", sensor_reset, 1'b1);
        step();
        check("pulse_ends", sensor_reset, 1'b0);
        if (k != 3) begin
            step();
            {hum_int, hum_float, temp_int, temp_float} = d;
            checksum = 8'(d[31:24] + d[23:16] + d[15:8] + d[7:0] + ((k == 1) ? 8'd1 : 8'd0));
            sensor_hold = 1'b1;
            sensor_error = (k == 2);
            repeat (3) step();
            sensor_error = 1'b0;
            repeat (3) step();
            sensor_hold = 1'b0;
            step();
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] est, input logic [1:0] eatt,
                           input logic [31:0] eod, input int bp);
        int pulses;
        bit got, busy_ok, stable;
        logic [31:0] d0;
        logic [1:0] s0, a0;
        request = 1'b1;
        step();
        request = 1'b0;
        check({tag, "_busy_on"}, busy, 1'b1);
        pulses = 0;
        got = 0;
        busy_ok = 1;
        for (int n = 0; n < 6000 && !got; n++) begin
            if (out_valid) got = 1;
            else if (sensor_reset) begin
                attempt(pulses);
                pulses++;
            end else begin
                if (!busy) busy_ok = 0;
                step();
            end
        end
        check({tag, "_valid_seen"}, got, 1'b1);
        check({tag, "_pulses"}, pulses, 32'(eatt) + 1);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_status"}, out_status, est);
        check({tag, "_attempts"}, out_attempts, eatt);
        check({tag, "_data"}, out_data, eod);
        d0 = out_data;
        s0 = out_status;
        a0 = out_attempts;
        stable = 1;
        for (int i = 0; i < bp; i++) begin
            request = (i % 5 == 0);
            step();
            if (out_valid !== 1'b1 || out_data !== d0 || out_status !== s0 || out_attempts !== a0 ||
                sensor_reset !== 1'b0 || busy !== 1'b1) stable = 0;
        end
        request = 1'b0;
        if (bp > 0) check({tag, "_backpressure_stable"}, stable, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_off"}, out_valid, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
        repeat (3) step();
        check({tag, "_no_queued_req"}, busy, 1'b0);
    endtask

    initial begin
        logic [1:0] st, att;
        logic [31:0] od;
        vt[0] = '{0, 0, 0, BASIC, 2'b00, 2'd0, BASIC, 0};
        vt[1] = '{1, 1, 1, BASIC, 2'b01, 2'd2, LG_EXP, 10};
        vt[2] = '{2, 0, 0, BASIC, 2'b00, 2'd1, BASIC, 0};
        vt[3] = '{3, 3, 3, BASIC, 2'b11, 2'd2, LG_EXP, 50};

        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b1;
        last_pulse = cyc;
        repeat (5) step();

        for (int i = 0; i < 4; i++) begin
            kind[0] = vt[i].k0;
            kind[1] = vt[i].k1;
            kind[2] = vt[i].k2;
            for (int j = 0; j < 3; j++) dat[j] = vt[i].d;
            run_txn($sformatf("vec%0d", i), vt[i].st, vt[i].att, vt[i].od, vt[i].bp);
            if (vt[i].st == 2'b00) lg_model = vt[i].od;
        end

        // Async reset while the decoder holds the line
        request = 1'b1;
        step();
        request = 1'b0;
        for (int n = 0; n < 500 && !sensor_reset; n++) step();
        check("arst_pulse_seen", sensor_reset, 1'b1);
        repeat (3) step();
        sensor_hold = 1'b1;
        repeat (3) step();
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("arst");
        sensor_hold = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        last_pulse = cyc;
        lg_model = '0;
        for (int j = 0; j < 3; j++) begin
            kind[j] = 0;
            dat[j] = $urandom;
        end
        model(st, att, od);
        run_txn("post_rst", st, att, od, 0);

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 3; j++) begin
                kind[j] = $urandom_range(0, 3);
                dat[j] = $urandom;
            end
            model(st, att, od);
            run_txn($sformatf("rnd%0d", t), st, att, od, $urandom_range(0, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dht11_read_ctrl.md
Name: dht11_read_ctrl

Overview:
- Sequences DHT11 decoder transactions on behalf of the command/UART layer; it sits directly downstream of the DHT11 decoder and consumes its outputs.
- Issues a read pulse to the decoder, tracks its hold/error flags, and enforces the sensor's minimum inter-read gap.
- Validates the checksum and retries on failure.
- Delivers one result word per request over a valid/ready handshake.

Parameters:
- MIN_GAP_CYCLES, 50_000_000: minimum clock cycles between consecutive read pulses (1 s at 50 MHz).
- TIMEOUT_CYCLES, 5_000_000: maximum cycles allowed from read pulse until sensor_hold falls (100 ms).
- MAX_RETRIES, 2: extra attempts after a failed read; total attempts = MAX_RETRIES+1.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- request  in  1  1-cycle read request from command layer
- busy  out  1  high from request acceptance until the result is consumed
- sensor_enable  out  1  enable to the DHT11 decoder
- sensor_reset  out  1  active-high start/reset pulse to the DHT11 decoder
- sensor_hold  in  1  decoder transaction in progress
- sensor_error  in  1  decoder error flag
- hum_int, hum_float, temp_int, temp_float, checksum  in  8 each  decoder data bytes
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  32  {hum_int, hum_float, temp_int, temp_float}
- out_status  out  2  00 ok, 01 checksum fail, 10 sensor error, 11 timeout
- out_attempts  out  2  attempts used minus 1 (saturating)

Behaviour:
- Reset (async, active-low) values:
  - busy=0, sensor_enable=1, sensor_reset=0, out_valid=0, out_data=0, out_status=00, out_attempts=0.
  - State=IDLE; gap counter=0, so the first pulse waits the full MIN_GAP_CYCLES, covering sensor power-up.
- Gap counter: increments each cycle, saturates at MIN_GAP_CYCLES, clears on every read pulse.
- IDLE:
  - request=1 → busy=1 next cycle, retry count=0, go to GAP.
  - request is ignored in every other state, with no queueing.
- GAP: wait until gap counter == MIN_GAP_CYCLES, then go to PULSE.
- PULSE:
  - sensor_reset=1 for exactly 2 cycles; the gap counter and timeout counter clear on the first pulse cycle.
  - Then go to WAIT_START.
- WAIT_START: wait for sensor_hold=1. Timeout counter expiry → fail with status 11.
- WAIT_DONE:
  - Any cycle with sensor_error=1 sets a sticky err_seen flag.
  - On sensor_hold falling (1→0) → CHECK.
  - Timeout expiry → fail with status 11.
- CHECK (1 cycle):
  - err_seen → status 10.
  - Else if (hum_int+hum_float+temp_int+temp_float) mod 256 != checksum → status 01.
  - Else status 00.
- Retry decision: status≠00 and retry count < MAX_RETRIES → increment retry count, clear err_seen, return to GAP. Otherwise go to OUTPUT.
- OUTPUT:
  - out_data, out_status and out_attempts are registered on entry; out_valid=1 is held, and the fields stay stable, until out_ready=1.
  - Transfer occurs on the cycle with out_valid & out_ready; next cycle out_valid=0, busy=0, state=IDLE.
  - out_ready=1 on the entry cycle completes the transfer after a single valid cycle.
- out_data on failure: zero (see optional feature).
- Timeout counter: TIMEOUT_CYCLES measured from the first PULSE cycle. Expiry is checked before the hold-fall check, so if both occur in the same cycle the timeout wins.
- Reset mid-transaction: immediate return to reset values; the decoder is not pulsed again until the gap elapses.
- Widths:
  - Gap and timeout counters are 26 bits.
  - The checksum sum uses an 8-bit wrap adder.
  - Retry count is 2 bits; MAX_RETRIES ≤ 3.

Optional Feature:
- Macro: DHT11_LAST_GOOD_EN.
- Defined:
  - A 32-bit last-good register is updated on every status-00 CHECK.
  - A failed result outputs the last-good value on out_data (zero if no good read has occurred since reset), with out_status still reporting the failure.
- Undefined: the register is absent; failed results output out_data=0.

Test Plan:
- Basic read (MIN_GAP_CYCLES=100, model returns 0x28,0x00,0x19,0x00, checksum 0x41):
  - request at cycle 5 → sensor_reset high for 2 cycles after 100 gap cycles.
  - Then out_valid with out_data=0x28001900, status 00, attempts 0.
- Checksum fail:
  - Model sends checksum 0x40 on every attempt → 3 pulses each ≥100 cycles apart.
  - Result status 01, attempts 2.
  - With DHT11_LAST_GOOD_EN after the prior good read, out_data=0x28001900; without it, 0.
- Sensor error then recovery:
  - Attempt 1 asserts sensor_error during hold; attempt 2 is clean.
  - Result status 00, attempts 1.
- Timeout (TIMEOUT_CYCLES=500):
  - sensor_hold never rises → 3 attempts.
  - Status 11; busy stays 1 until the output handshake completes.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 50 cycles while pulsing request → out_valid and out_data stay stable, no new sensor_reset.
  - Transfer completes on the cycle out_ready=1; busy=0 the next cycle.
- Async reset:
  - Assert reset during WAIT_DONE → all outputs at reset values within the same cycle, without waiting for a clock edge.
  - A new request after release waits the full gap before pulsing.
